// File: rtl/pll_drp_sequencer.sv
// Reprograms a 7-series PLL/MMCM over DRP as a stream of read-modify-write entries,
// holding the PLL in reset throughout, then releasing it and waiting for lock.
`timescale 1ns/1ps
module pll_drp_sequencer #(
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  input  logic        ent_valid,
  output logic        ent_ready,
  input  logic [6:0]  ent_addr,
  input  logic [15:0] ent_data,
  input  logic [15:0] ent_mask,
  input  logic        ent_last,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int CNT_MAX0 = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > RST_HOLD) ? CNT_MAX0 : RST_HOLD;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_HOLD_PRE   = 4'd1;
  localparam logic [3:0] S_WAIT_ENTRY = 4'd2;
  localparam logic [3:0] S_READ       = 4'd3;
  localparam logic [3:0] S_READ_WAIT  = 4'd4;
  localparam logic [3:0] S_WRITE      = 4'd5;
  localparam logic [3:0] S_WRITE_WAIT = 4'd6;
  localparam logic [3:0] S_HOLD_POST  = 4'd7;
  localparam logic [3:0] S_WAIT_LOCK  = 4'd8;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DRDY = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_addr;
  logic [15:0]      r_data;
  logic [15:0]      r_mask;
  logic             r_last;
  logic [15:0]      r_wr;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [1:0]       r_err_code;
  logic             r_pll_rst;
  logic             r_lock_meta;
  logic             r_lock_sync;

  logic w_cnt_zero;
  logic w_drdy_tc;
  logic w_lock_tc;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_drdy_tc  = (r_cnt == CNT_W'(DRDY_TIMEOUT - 1));
  assign w_lock_tc  = (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  // DRP strobes decode straight from state so each access is exactly one cycle wide.
  assign drp_den   = (r_state == S_READ) || (r_state == S_WRITE);
  assign drp_dwe   = (r_state == S_WRITE);
  assign drp_daddr = r_addr;
  assign drp_di    = r_wr;
  // Combinational so the host can advance its stream before WAIT_ENTRY samples ent_valid.
  assign ent_ready = (r_state == S_WRITE_WAIT) && drp_drdy;

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_err_code;
  assign pll_rst  = r_pll_rst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the two flops a true 2-stage synchronizer.
      r_lock_meta <= pll_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry latches are reset too, so drp_daddr/drp_di read 0 out of reset.
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_last     <= 1'b0;
      r_wr       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_pll_rst  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_busy     <= 1'b1;
            r_pll_rst  <= 1'b1;
            r_cnt      <= CNT_W'(RST_HOLD - 1);
            r_state    <= S_HOLD_PRE;
          end
        end
        S_HOLD_PRE: begin
          if (w_cnt_zero) r_state <= S_WAIT_ENTRY;
          else            r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_WAIT_ENTRY: begin
          if (ent_valid) begin
            r_addr  <= ent_addr;
            r_data  <= ent_data;
            r_mask  <= ent_mask;
            r_last  <= ent_last;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_cnt   <= '0;
          r_state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          // drdy wins over the terminal count when both land in the same cycle.
          if (drp_drdy) begin
            r_wr    <= (drp_do & r_mask) | r_data;
            r_state <= S_WRITE;
          end else if (w_drdy_tc) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pll_rst  <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= ERR_DRDY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          r_cnt   <= '0;
          r_state <= S_WRITE_WAIT;
        end
        S_WRITE_WAIT: begin
          if (drp_drdy) begin
            if (r_last) begin
              r_cnt   <= CNT_W'(RST_HOLD - 1);
              r_state <= S_HOLD_POST;
            end else begin
              r_state <= S_WAIT_ENTRY;
            end
          end else if (w_drdy_tc) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pll_rst  <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= ERR_DRDY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLD_POST: begin
          if (w_cnt_zero) begin
            r_pll_rst <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_WAIT_LOCK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_sync) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_lock_tc) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= ERR_LOCK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_pll_rst <= 1'b0;
        end
      endcase
    end
  end

endmodule
